// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: board geometry defaults, display codes,
// reporter state encoding and the trailer status decode.
package minesweeper_pkg;

    localparam int GRID_DIM = 5;
    localparam int N_CELLS  = GRID_DIM * GRID_DIM;

    localparam logic [3:0] CODE_HIDDEN = 4'hA;
    localparam logic [3:0] CODE_MINE   = 4'hB;
    localparam logic [3:0] CODE_WIN    = 4'hC;
    localparam logic [3:0] CODE_LOSE   = 4'hD;
    localparam logic [3:0] CODE_PLAY   = 4'hE;
    localparam logic [3:0] CODE_FLAG   = 4'hF;
    localparam logic [4:0] TRAILER_IDX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DONE    = 2'd3
    } report_state_t;

    // A lost game outranks a won one when both flags are present
    function automatic logic [3:0] trailer_code(input logic gameover, input logic win);
        if (gameover) begin
            return CODE_LOSE;
        end
        if (win) begin
            return CODE_WIN;
        end
        return CODE_PLAY;
    endfunction

endpackage

// File: rtl/neighbor_counter.sv
// Combinational count of mines adjacent to one cell of the board.
// Edges are clipped (no wrap-around) and the cell itself is never counted.
module neighbor_counter #(
    parameter int GRID_DIM = minesweeper_pkg::GRID_DIM
) (
    input  logic [GRID_DIM*GRID_DIM-1:0] mines,
    input  logic [4:0]                   cell_idx,
    output logic [3:0]                   count
);

    logic [2:0] row;
    logic [2:0] col;

    // Split the linear row-major index into row and column
    always_comb begin
        row = '0;
        col = '0;
        for (int unsigned r = 0; r < GRID_DIM; r++) begin
            for (int unsigned c = 0; c < GRID_DIM; c++) begin
                if (32'(cell_idx) == r * GRID_DIM + c) begin
                    row = 3'(r);
                    col = 3'(c);
                end
            end
        end
    end

    // Scan every cell and count mines lying within one step of (row, col)
    always_comb begin
        count = '0;
        for (int unsigned r = 0; r < GRID_DIM; r++) begin
            for (int unsigned c = 0; c < GRID_DIM; c++) begin
                if (mines[r * GRID_DIM + c]
                    && !(3'(r) == row && 3'(c) == col)
                    && (3'(r) + 3'd1 >= row) && (3'(r) <= row + 3'd1)
                    && (3'(c) + 3'd1 >= col) && (3'(c) <= col + 3'd1)) begin
                    count = count + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/board_reporter.sv
// Streams a snapshot of the minesweeper board as one code per cell followed
// by a status trailer, over a valid/ready handshake.
// Optional: define SCORE_TRAILER_EN to present the snapshot score on the
// trailer beat; otherwise out_score is tied to zero.
module board_reporter #(
    parameter int GRID_DIM = minesweeper_pkg::GRID_DIM,
    parameter int CODE_W   = 4
) (
    input  logic                         in_clka,
    input  logic                         in_restart,
    input  logic                         in_report,
    input  logic [GRID_DIM*GRID_DIM-1:0] in_mines,
    input  logic [GRID_DIM*GRID_DIM-1:0] in_cleared,
    input  logic                         in_gameover,
    input  logic                         in_win,
    input  logic [31:0]                  in_global_score,
    input  logic                         in_ready,
    output logic                         out_valid,
    output logic [4:0]                   out_cell_idx,
    output logic [CODE_W-1:0]            out_cell_code,
    output logic                         out_last,
    output logic                         out_busy,
    output logic                         out_frame_done,
    output logic [31:0]                  out_score
);

    import minesweeper_pkg::*;

    localparam int         NCELLS   = GRID_DIM * GRID_DIM;
    localparam logic [4:0] LAST_IDX = 5'(NCELLS - 1);

    report_state_t     state;
    report_state_t     state_next;
    logic [4:0]        cell_cnt;
    logic [NCELLS-1:0] snap_mines;
    logic [NCELLS-1:0] snap_cleared;
    logic              snap_gameover;
    logic              snap_win;
    logic [3:0]        nbr_count;
    logic [3:0]        cell_code;

    neighbor_counter #(
        .GRID_DIM (GRID_DIM)
    ) u_neighbor_counter (
        .mines    (snap_mines),
        .cell_idx (cell_cnt),
        .count    (nbr_count)
    );

    // State register; restart abandons any frame in flight
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Board snapshot capture and cell counter advance on accepted beats
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            cell_cnt      <= '0;
            snap_mines    <= '0;
            snap_cleared  <= '0;
            snap_gameover <= 1'b0;
            snap_win      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_report) begin
                        cell_cnt      <= '0;
                        snap_mines    <= in_mines;
                        snap_cleared  <= in_cleared;
                        snap_gameover <= in_gameover;
                        snap_win      <= in_win;
                    end
                end
                ST_SEND: begin
                    if (in_ready && cell_cnt != LAST_IDX) begin
                        cell_cnt <= cell_cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-cell code from the snapshot, highest priority first
    always_comb begin
        cell_code = CODE_HIDDEN;
        if (snap_mines[cell_cnt] && snap_gameover) begin
            cell_code = CODE_MINE;
        end else if (snap_mines[cell_cnt] && snap_win) begin
            cell_code = CODE_FLAG;
        end else if (snap_cleared[cell_cnt] && !snap_mines[cell_cnt]) begin
            cell_code = nbr_count;
        end
    end

    // Next state and beat outputs; outputs depend on state only, never in_ready
    always_comb begin
        state_next     = state;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        out_busy       = 1'b0;
        out_frame_done = 1'b0;
        out_cell_idx   = '0;
        out_cell_code  = '0;
        case (state)
            ST_IDLE: begin
                if (in_report) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid     = 1'b1;
                out_busy      = 1'b1;
                out_cell_idx  = cell_cnt;
                out_cell_code = CODE_W'(cell_code);
                if (in_ready && cell_cnt == LAST_IDX) begin
                    state_next = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                out_valid     = 1'b1;
                out_last      = 1'b1;
                out_busy      = 1'b1;
                out_cell_idx  = TRAILER_IDX;
                out_cell_code = CODE_W'(trailer_code(snap_gameover, snap_win));
                if (in_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_busy       = 1'b1;
                out_frame_done = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef SCORE_TRAILER_EN
    logic [31:0] snap_score;

    // Score captured alongside the board snapshot
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            snap_score <= '0;
        end else if (state == ST_IDLE && in_report) begin
            snap_score <= in_global_score;
        end
    end

    assign out_score = (state == ST_TRAILER) ? snap_score : '0;
`else
    logic unused_score;

    assign unused_score = ^in_global_score;
    assign out_score    = '0;
`endif

endmodule
